// File: rtl/data_mem_responder.sv
// Data-memory responder for the RV32I Memory-stage load/store port.
// Build option: define MISALIGN_TRAP_EN to report misaligned accesses as errors.
`timescale 1ns/1ps

module data_mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_adrs,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [3:0] LP_WAIT_INIT =
        (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t r_state;
    state_t w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;

    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_adrs;
    logic [31:0] r_wdata;

    logic [31:0] r_mem [DEPTH];

    logic                  w_accept;
    logic                  w_enter_resp;
    logic                  w_we;
    logic [2:0]            w_funct3;
    logic [31:0]           w_adrs;
    logic [31:0]           w_wdata;
    logic [1:0]            w_size;
    logic                  w_st_legal;
    logic                  w_ld_legal;
    logic                  w_misal;
    logic                  w_trap;
    logic [1:0]            w_off;
    logic                  w_err;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [3:0]            w_be;
    logic [31:0]           w_wdat;
    logic                  w_do_write;
    logic [31:0]           w_word;
    logic [15:0]           w_sh;
    logic [31:0]           w_ld_data;
    logic [31:0]           w_rsp_data;
    logic                  w_unused;

    assign w_accept  = req_valid && (r_state == S_IDLE);
    assign req_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign rsp_valid = (r_state == S_RESP);

    // Next-state and wait-counter logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (WAIT_CYCLES == 0) begin
                        w_state_nxt = S_RESP;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = LP_WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // State register and wait counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Capture the accepted request; later inputs are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we     <= 1'b0;
            r_funct3 <= 3'd0;
            r_adrs   <= 32'd0;
            r_wdata  <= 32'd0;
        end else if (w_accept) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_adrs   <= req_adrs;
            r_wdata  <= req_wdata;
        end
    end

    // With zero wait states the access happens on the accept edge itself,
    // so the live request is used instead of the not-yet-latched copy.
    assign w_enter_resp = !reset && (r_state != S_RESP) &&
                          (w_state_nxt == S_RESP);
    assign w_we     = (r_state == S_IDLE) ? req_we     : r_we;
    assign w_funct3 = (r_state == S_IDLE) ? req_funct3 : r_funct3;
    assign w_adrs   = (r_state == S_IDLE) ? req_adrs   : r_adrs;
    assign w_wdata  = (r_state == S_IDLE) ? req_wdata  : r_wdata;

    assign w_size     = w_funct3[1:0];
    assign w_st_legal = !w_funct3[2] && (w_size != 2'b11);
    assign w_ld_legal = (w_size != 2'b11) && !(w_funct3[2] && w_funct3[1]);
    assign w_misal    = ((w_size == 2'd1) && w_adrs[0]) ||
                        ((w_size == 2'd2) && (w_adrs[1:0] != 2'b00));
    assign w_idx      = w_adrs[ADDR_WIDTH+1:2];
    assign w_unused   = ^{w_adrs[31:ADDR_WIDTH+2], w_misal};

    // Alignment policy: trap, or silently clear the low offset bits.
    always_comb begin
`ifdef MISALIGN_TRAP_EN
        w_trap = w_misal;
        w_off  = w_adrs[1:0];
`else
        w_trap = 1'b0;
        w_off  = w_adrs[1:0];
        if (w_size == 2'd1) begin
            w_off = {w_adrs[1], 1'b0};
        end else if (w_size == 2'd2) begin
            w_off = 2'b00;
        end
`endif
    end

    assign w_err = (w_we ? !w_st_legal : !w_ld_legal) || w_trap;

    // Byte-lane enables and lane-replicated store data.
    always_comb begin
        w_be   = 4'b0000;
        w_wdat = 32'd0;
        case (w_size)
            2'd0: begin
                w_be   = 4'b0001 << w_off;
                w_wdat = {4{w_wdata[7:0]}};
            end
            2'd1: begin
                w_be   = 4'b0011 << w_off;
                w_wdat = {2{w_wdata[15:0]}};
            end
            2'd2: begin
                w_be   = 4'b1111;
                w_wdat = w_wdata;
            end
            default: begin
                w_be   = 4'b0000;
                w_wdat = 32'd0;
            end
        endcase
    end

    assign w_do_write = w_enter_resp && w_we && !w_err;

    // Word array with byte-lane writes; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdat[8*i +: 8];
                end
            end
        end
    end

    assign w_word = r_mem[w_idx];
    assign w_sh   = 16'(w_word >> {w_off, 3'b000});

    // Load extraction with sign or zero extension.
    always_comb begin
        w_ld_data = 32'd0;
        case (w_funct3)
            3'b000:  w_ld_data = {{24{w_sh[7]}}, w_sh[7:0]};
            3'b100:  w_ld_data = {24'd0, w_sh[7:0]};
            3'b001:  w_ld_data = {{16{w_sh[15]}}, w_sh[15:0]};
            3'b101:  w_ld_data = {16'd0, w_sh[15:0]};
            3'b010:  w_ld_data = w_word;
            default: w_ld_data = 32'd0;
        endcase
    end

    assign w_rsp_data = (w_we || w_err) ? 32'd0 : w_ld_data;

    // Response data and error, held until the next response.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else if (w_enter_resp) begin
            rsp_rdata <= w_rsp_data;
            rsp_err   <= w_err;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed cases then random traffic.
// Expected responses come from a word-array model of the load/store rules.
`timescale 1ns/1ps

module tb_data_mem_responder;

    localparam int W     = 2;
    localparam int AW    = 10;
    localparam int DEPTH = 2 ** AW;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_adrs = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    typedef struct {
        int          cyc;
        logic [31:0] rd;
        logic        e;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem[int];
    int          ncyc = 0;
    int          checks = 0;
    int          errors = 0;

    data_mem_responder #(
        .ADDR_WIDTH (AW),
        .WAIT_CYCLES(W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_funct3(req_funct3),
        .req_adrs  (req_adrs),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, req);
        end
    endtask

    // Reference model: applies one access to the word array.
    function automatic void model(input logic we, input logic [2:0] f3,
                                  input logic [31:0] a,
                                  input logic [31:0] wd,
                                  output logic [31:0] rd,
                                  output logic e);
        int          idx;
        int          sz;
        int          off;
        bit          legal;
        bit          mis;
        logic [31:0] w;
        logic [31:0] sh;
        rd  = 32'd0;
        e   = 1'b0;
        sz  = int'(f3[1:0]);
        idx = int'((a >> 2) % DEPTH);
        if (we) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        else    legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
        if (!legal) begin
            e = 1'b1;
            return;
        end
        mis = (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 2'b00);
`ifdef MISALIGN_TRAP_EN
        if (mis) begin
            e = 1'b1;
            return;
        end
`else
        if (mis && sz == 1) a[0] = 1'b0;
        if (mis && sz == 2) a[1:0] = 2'b00;
`endif
        off = int'(a[1:0]);
        w   = mem[idx];
        if (we) begin
            if (sz == 0) w[8*off +: 8] = wd[7:0];
            else if (sz == 1) w[8*off +: 16] = wd[15:0];
            else w = wd;
            mem[idx] = w;
        end else begin
            sh = w >> (8 * off);
            case (f3)
                3'd0: rd = {{24{sh[7]}}, sh[7:0]};
                3'd4: rd = {24'd0, sh[7:0]};
                3'd1: rd = {{16{sh[15]}}, sh[15:0]};
                3'd5: rd = {16'd0, sh[15:0]};
                default: rd = w;
            endcase
        end
    endfunction

    // Monitor: every response must match the queue head in cycle and value.
    always @(negedge clk) begin
        ncyc++;
        if (exp_q.size() > 0 && exp_q[0].cyc < ncyc) begin
            checks++;
            errors++;
            $display("FAIL rsp_missing due %0d now %0d", exp_q[0].cyc, ncyc);
            void'(exp_q.pop_front());
        end
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected at cycle %0d", ncyc);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                chk("rsp_cycle", 32'(ncyc), 32'(x.cyc));
                chk("rsp_rdata", rsp_rdata, x.rd);
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, x.e});
            end
        end
    end

    // Issue one request and wait for its response (entered at negedge+1).
    task automatic issue(input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input bit hold);
        logic [31:0] er;
        logic        ee;
        int          n;
        exp_t        x;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout req_ready %b want 1", req_ready);
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_adrs   = a;
        req_wdata  = wd;
        model(we, f3, a, wd, er, ee);
        x.cyc = ncyc + W + 1;
        x.rd  = er;
        x.e   = ee;
        exp_q.push_back(x);
        @(negedge clk); #1;
        n = 0;
        while (!rsp_valid && n < 40) begin
            chk("busy_ready", {30'd0, req_ready, busy}, 32'd1);
            if (hold) begin
                req_valid  = 1'b1;
                req_we     = 1'($urandom());
                req_funct3 = 3'($urandom());
                req_adrs   = $urandom();
                req_wdata  = $urandom();
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk); #1;
            n++;
        end
        chk("resp_busy", {30'd0, req_ready, busy}, 32'd1);
        req_valid = 1'b0;
        @(negedge clk); #1;
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  f3;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", {31'd0, rsp_err}, 32'd0);
        reset = 1'b0;
        @(negedge clk); #1;

        issue(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0);
        issue(1'b0, 3'd2, 32'h10, 32'h0, 1'b0);

        issue(1'b1, 3'd2, 32'h20, 32'h80FF7F01, 1'b0);
        issue(1'b0, 3'd0, 32'h21, 32'h0, 1'b0);
        issue(1'b0, 3'd0, 32'h22, 32'h0, 1'b0);
        issue(1'b0, 3'd4, 32'h23, 32'h0, 1'b0);
        issue(1'b0, 3'd1, 32'h22, 32'h0, 1'b0);
        issue(1'b0, 3'd5, 32'h22, 32'h0, 1'b0);

        issue(1'b1, 3'd2, 32'h30, 32'h11223344, 1'b0);
        issue(1'b1, 3'd0, 32'h31, 32'h000000AA, 1'b0);
        issue(1'b0, 3'd2, 32'h30, 32'h0, 1'b0);
        issue(1'b1, 3'd1, 32'h32, 32'h00005566, 1'b0);
        issue(1'b0, 3'd2, 32'h30, 32'h0, 1'b0);

        issue(1'b1, 3'd2, 32'h04, 32'hCAFEF00D, 1'b0);
        issue(1'b0, 3'd2, 32'h06, 32'h0, 1'b0);

        issue(1'b1, 3'd2, 32'h40, 32'h01020304, 1'b0);
        issue(1'b1, 3'd3, 32'h40, 32'hFFFFFFFF, 1'b1);
        issue(1'b0, 3'd2, 32'h40, 32'h0, 1'b0);

        // Abort a store during its wait states; no response, no write.
        issue(1'b1, 3'd2, 32'h50, 32'h0, 1'b0);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'd2;
        req_adrs   = 32'h50;
        req_wdata  = 32'h12345678;
        @(negedge clk); #1;
        req_valid = 1'b0;
        chk("abort_in_wait", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk); #1;
        reset = 1'b0;
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_valid", {31'd0, rsp_valid}, 32'd0);
        repeat (4) @(negedge clk);
        #1;
        issue(1'b0, 3'd2, 32'h50, 32'h0, 1'b0);

        // Random traffic over a preloaded region, with aliasing upper bits.
        for (int i = 0; i < 16; i++) begin
            a = ($urandom() & 32'hFFFF_F000) | (32'h100 + 32'(4 * i));
            issue(1'b1, 3'd2, a, $urandom(), 1'b0);
        end
        for (int i = 0; i < 200; i++) begin
            a = ($urandom() & 32'hFFFF_F000) | 32'h100 |
                (32'($urandom_range(0, 15)) << 2) |
                32'($urandom_range(0, 3));
            f3 = 3'($urandom_range(0, 7));
            issue(1'($urandom()), f3, a, $urandom(),
                  $urandom_range(0, 3) == 0);
        end

        repeat (5) @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
